gshare_predictor: RTL

Parametrised conditional-branch direction predictor for the instruction-fetch stage. It is the successor of the fixed 128-entry bimodal 2-bit table, with configurable table depth and counter width, and a selectable global-history (gshare) indexing mode. The fetch stage gets a combinational prediction and a history snapshot. The ROB returns that snapshot at commit to train the table, and at a mispredict to repair the history.

---
 rtl/gshare_predictor_pkg.sv | 30 +++
 rtl/const_def.v | 7 +
 rtl/pred_ghr.sv | 50 +++++
 rtl/gshare_predictor.sv | 80 ++++++++
 4 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare predictor: mode constants and counter step helper.
`ifndef PRED_BIMODAL
`define PRED_BIMODAL 0
`endif
`ifndef PRED_GSHARE
`define PRED_GSHARE 1
`endif

package gshare_predictor_pkg;

  // Widest counter the table supports; narrower counters are zero-extended into the helper.
  localparam int MAX_CNT_W = 4;

  // One saturating step of a direction counter toward taken or not-taken.
  function automatic logic [MAX_CNT_W-1:0] sat_update(
    input logic [MAX_CNT_W-1:0] cnt,
    input logic                 taken,
    input logic [MAX_CNT_W-1:0] cnt_max
  );
    logic [MAX_CNT_W-1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != cnt_max) res = cnt + 4'd1;
    end else begin
      if (cnt != '0) res = cnt - 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/const_def.v
// Indexing-mode constants for the branch direction predictor.
`ifndef PRED_BIMODAL
`define PRED_BIMODAL 0
`endif
`ifndef PRED_GSHARE
`define PRED_GSHARE 1
`endif

// File: rtl/pred_ghr.sv
// Global history register: speculative shift at fetch, restore at mispredict (restore wins).
module pred_ghr #(
  parameter int HIST_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              restore_en,
  input  logic [HIST_W-1:0] restore_hist,
  input  logic              restore_bit,
  output logic [HIST_W-1:0] hist
);

  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] restore_val;
  logic [HIST_W-1:0] shift_val;
  logic [HIST_W-1:0] hist_d;

  // The oldest bit of the snapshot falls off when the actual outcome is appended.
  logic unused_restore_msb;
  assign unused_restore_msb = restore_hist[HIST_W-1];

  generate
    if (HIST_W == 1) begin : g_one
      assign restore_val = restore_bit;
      assign shift_val   = shift_bit;
    end else begin : g_multi
      assign restore_val = {restore_hist[HIST_W-2:0], restore_bit};
      assign shift_val   = {hist_q[HIST_W-2:0], shift_bit};
    end
  endgenerate

  // Next history: repair from the committed snapshot beats a speculative shift.
  always_comb begin
    hist_d = hist_q;
    if (restore_en)    hist_d = restore_val;
    else if (shift_en) hist_d = shift_val;
  end

  // History register with synchronous clear and global freeze.
  always_ff @(posedge clk) begin
    if (rst)      hist_q <= '0;
    else if (rdy) hist_q <= hist_d;
  end

  assign hist = hist_q;

endmodule

// File: rtl/gshare_predictor.sv
// Parametrised bimodal/gshare branch direction predictor with flop-based counter table.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W  = 7,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 7,
  parameter int MODE   = `PRED_GSHARE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [31:0]       if_pc,
  input  logic              if_br_valid,
  output logic              predict,
  output logic [HIST_W-1:0] predict_hist,
  input  logic              commit_valid,
  input  logic [31:0]       commit_pc,
  input  logic [HIST_W-1:0] commit_hist,
  input  logic              commit_taken,
  input  logic              mispredict
);

  localparam int               ENTRIES  = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam bit               USE_HIST = (MODE == `PRED_GSHARE);

  logic [CNT_W-1:0]  table_q [ENTRIES];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  commit_idx;
  logic [CNT_W-1:0]  commit_cnt_next;

  // Only the word-aligned index bits of the PCs select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:IDX_W+2],
                            commit_pc[1:0], commit_pc[31:IDX_W+2]};

  // Fetch index uses the live GHR; commit index uses the snapshot taken at prediction time.
  always_comb begin
    fetch_idx  = if_pc[IDX_W+1:2];
    commit_idx = commit_pc[IDX_W+1:2];
    if (USE_HIST) begin
      fetch_idx  = fetch_idx ^ IDX_W'(ghr);
      commit_idx = commit_idx ^ IDX_W'(commit_hist);
    end
  end

  // Prediction reads the pre-update table, so a same-cycle commit is not forwarded.
  assign predict      = table_q[fetch_idx][CNT_W-1];
  assign predict_hist = ghr;

  assign commit_cnt_next = CNT_W'(sat_update(MAX_CNT_W'(table_q[commit_idx]),
                                             commit_taken, MAX_CNT_W'(CNT_MAX)));

  // Counter table: full clear to weakly not-taken, otherwise train on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
    end else if (rdy && commit_valid) begin
      table_q[commit_idx] <= commit_cnt_next;
    end
  end

  pred_ghr #(
    .HIST_W(HIST_W)
  ) u_ghr (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .shift_en    (if_br_valid),
    .shift_bit   (predict),
    .restore_en  (commit_valid & mispredict),
    .restore_hist(commit_hist),
    .restore_bit (commit_taken),
    .hist        (ghr)
  );

endmodule
